// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with frame-synchronous display update,
// leading-zero blanking, per-digit blink, decimal points and optional hex decode.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 100000,
   parameter int BLINK_FRAMES = 64,
   parameter bit HEX_MODE     = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   tub_sel,
   output logic                    frame_done
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   logic [PW-1:0]           prescaler;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] pend_data, act_data;
   logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
   logic [BW-1:0]           blink_cnt;
   logic                    blink_phase;
   logic                    tick, frame_wrap;
   logic [3:0]              nibbles [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   lz_zero;
   logic [NUM_DIGITS-1:0]   tub_nxt;
   logic [7:0]              seg_nxt;

   assign tick       = (prescaler == PW'(SCAN_DIV - 1));
   assign frame_wrap = tick && (idx == IW'(NUM_DIGITS - 1));

   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] g;
      case (code)
         4'h0:    g = 7'b1111110;
         4'h1:    g = 7'b0110000;
         4'h2:    g = 7'b1101101;
         4'h3:    g = 7'b1111001;
         4'h4:    g = 7'b0110011;
         4'h5:    g = 7'b1011011;
         4'h6:    g = 7'b1011111;
         4'h7:    g = 7'b1110000;
         4'h8:    g = 7'b1111111;
         4'h9:    g = 7'b1111011;
         4'hA:    g = 7'b1110111;
         4'hB:    g = 7'b0011111;
         4'hC:    g = 7'b1001110;
         4'hD:    g = 7'b0111101;
         4'hE:    g = 7'b1001111;
         default: g = 7'b1000111;
      endcase
      if (!HEX_MODE && code > 4'h9) g = 7'b0000000;
      return g;
   endfunction

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
      assign nibbles[i] = act_data[4*i +: 4];
   end

   // lz_zero[i]: nibbles i..NUM_DIGITS-1 of the shown value are all zero
   always_comb begin
      logic run;
      run     = 1'b1;
      lz_zero = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run        = run & (nibbles[i] == 4'h0);
         lz_zero[i] = run;
      end
   end

   // Next-cycle outputs; blanking on the tick cycle makes the first cycle of each slot dark.
   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      tub_nxt = '0;
      seg_nxt = '0;
      if (!tick) begin
         tub_nxt = ONE_HOT0 << idx;
         if (!(blink_phase && blink_en[idx])) begin
            seg_nxt[0] = act_dp[idx];
            if (!(blank_lz && idx != '0 && lz_zero[idx]))
               seg_nxt[7:1] = decode(nibbles[idx]);
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler   <= '0;
         idx         <= '0;
         pend_data   <= '0;
         pend_dp     <= '0;
         act_data    <= '0;
         act_dp      <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         frame_done  <= 1'b0;
         seg_out     <= '0;
         tub_sel     <= '0;
      end else begin
         prescaler  <= tick ? '0 : prescaler + PW'(1);
         frame_done <= frame_wrap;
         seg_out    <= seg_nxt;
         tub_sel    <= tub_nxt;
         if (tick) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
         if (load) begin
            pend_data <= data_in;
            pend_dp   <= dp_in;
         end
         // A load coinciding with the wrap goes straight to the display.
         if (frame_wrap) begin
            act_data <= load ? data_in : pend_data;
            act_dp   <= load ? dp_in   : pend_dp;
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + BW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: 4 digits, 4 clk per slot, 2-frame blink; hex and decimal
// instances share stimulus and are checked from a per-slot scoreboard plus hand sequences.
module tb_seven_seg_scan_driver;

   localparam int N    = 4;
   localparam int SCAN = 4;
   localparam int BF   = 2;

   localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
   localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
   localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, SA = 7'b1110111, SC = 7'b1001110;
   localparam logic [6:0] SE = 7'b1001111, SF = 7'b1000111, SX = 7'b0000000;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [4*N-1:0] data_in;
   logic [N-1:0]   dp_in;
   logic           load;
   logic           blank_lz;
   logic [N-1:0]   blink_en;
   logic [7:0]     seg_h, seg_d;
   logic [N-1:0]   tub_h, tub_d;
   logic           fd_h, fd_d;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SCAN), .BLINK_FRAMES(BF), .HEX_MODE(1'b1)) u_hex (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .blink_en(blink_en), .seg_out(seg_h), .tub_sel(tub_h), .frame_done(fd_h));

   seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SCAN), .BLINK_FRAMES(BF), .HEX_MODE(1'b0)) u_dec (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .blink_en(blink_en), .seg_out(seg_d), .tub_sel(tub_d), .frame_done(fd_d));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: one entry per digit slot of a frame, compared on the slot's first lit cycle.
   typedef struct packed {
      logic [N-1:0] tub;
      logic [7:0]   seg_h;
      logic [7:0]   seg_d;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   logic [N-1:0] prev_tub = '0;

   always @(negedge clk) begin
      if (tub_h != '0 && prev_tub == '0 && sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("slot tub hex", tub_h, mon_e.tub);
         check("slot tub dec", tub_d, mon_e.tub);
         check("slot seg hex", seg_h, mon_e.seg_h);
         check("slot seg dec", seg_d, mon_e.seg_d);
      end
      prev_tub = tub_h;
   end

   typedef struct packed {
      logic [4*N-1:0]    data;
      logic [N-1:0]      dp;
      logic              blz;
      logic [N-1:0][7:0] eh;
      logic [N-1:0][7:0] ed;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mk(input logic [15:0] data, input logic [3:0] dp, input logic blz,
                               input logic [3:0][7:0] eh, input logic [3:0][7:0] ed);
      vec_t v;
      v.data = data; v.dp = dp; v.blz = blz; v.eh = eh; v.ed = ed;
      return v;
   endfunction

   task automatic push_frame(input logic [3:0][7:0] eh, input logic [3:0][7:0] ed);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.tub   = N'(1) << i;
         e.seg_h = eh[i];
         e.seg_d = ed[i];
         sb.push_back(e);
      end
   endtask

   task automatic wait_frame();
      bit got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         got = fd_h;
      end
      if (!got) check("frame_done timeout", fd_h, 1);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         check("scoreboard drain timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic pulse_load(input logic [15:0] data, input logic [3:0] dp);
      data_in = data;
      dp_in   = dp;
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
   endtask

   initial begin
      vecs[0] = mk(16'h1234, 4'b0000, 1'b0, {{S1,1'b0},{S2,1'b0},{S3,1'b0},{S4,1'b0}},
                                            {{S1,1'b0},{S2,1'b0},{S3,1'b0},{S4,1'b0}});
      vecs[1] = mk(16'h00A5, 4'b0000, 1'b1, {{SX,1'b0},{SX,1'b0},{SA,1'b0},{S5,1'b0}},
                                            {{SX,1'b0},{SX,1'b0},{SX,1'b0},{S5,1'b0}});
      vecs[2] = mk(16'hCAFE, 4'b0100, 1'b0, {{SC,1'b0},{SA,1'b1},{SF,1'b0},{SE,1'b0}},
                                            {{SX,1'b0},{SX,1'b1},{SX,1'b0},{SX,1'b0}});
      vecs[3] = mk(16'h0000, 4'b1111, 1'b1, {{SX,1'b1},{SX,1'b1},{SX,1'b1},{S0,1'b1}},
                                            {{SX,1'b1},{SX,1'b1},{SX,1'b1},{S0,1'b1}});
      vecs[4] = mk(16'h0070, 4'b0010, 1'b1, {{SX,1'b0},{SX,1'b0},{S7,1'b1},{S0,1'b0}},
                                            {{SX,1'b0},{SX,1'b0},{S7,1'b1},{S0,1'b0}});
      vecs[5] = mk(16'h8096, 4'b1000, 1'b1, {{S8,1'b1},{S0,1'b0},{S9,1'b0},{S6,1'b0}},
                                            {{S8,1'b1},{S0,1'b0},{S9,1'b0},{S6,1'b0}});

      rst_n = 1'b0; data_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0; blink_en = '0;
      repeat (3) @(negedge clk);
      check("reset seg", seg_h, 8'h00);
      check("reset tub", tub_h, 0);
      check("reset frame_done", fd_h, 0);

      // Scan pattern for two frames after release: slot cycle 0 dark, then one-hot for 3 cycles.
      rst_n = 1'b1;
      #1 check("scan tub c0", tub_h, 0);
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk);
         check("scan tub", tub_h, ((c % 4) == 0) ? 0 : (1 << ((c / 4) % 4)));
         if (c % 8 == 0) check("scan frame_done", fd_h, (c % 16) == 0);
         if (c == 1) check("scan seg zero digit", seg_h, {S0, 1'b0});
      end

      for (int i = 0; i < 6; i++) begin
         wait_frame();
         repeat (3) @(negedge clk);
         blank_lz = vecs[i].blz;
         pulse_load(vecs[i].data, vecs[i].dp);
         wait_frame();
         push_frame(vecs[i].eh, vecs[i].ed);
         wait_empty();
      end

      // Mid-frame loads: current frame keeps 8096; second load overwrites the first.
      wait_frame();
      repeat (2) @(negedge clk);
      pulse_load(16'h5678, 4'b0000);
      pulse_load(16'h0009, 4'b0000);
      repeat (9) @(negedge clk);
      check("no tear tub", tub_h, 4'b1000);
      check("no tear seg", seg_h, {S8, 1'b1});
      wait_frame();
      push_frame({{SX,1'b0},{SX,1'b0},{SX,1'b0},{S9,1'b0}}, {{SX,1'b0},{SX,1'b0},{SX,1'b0},{S9,1'b0}});
      wait_empty();

      // Load on the wrap-tick cycle reaches the very next frame.
      wait_frame();
      repeat (15) @(negedge clk);
      pulse_load(16'h9999, 4'b0000);
      check("wrap load frame_done", fd_h, 1);
      push_frame({{S9,1'b0},{S9,1'b0},{S9,1'b0},{S9,1'b0}}, {{S9,1'b0},{S9,1'b0},{S9,1'b0},{S9,1'b0}});
      wait_empty();

      // Reset asserted mid-slot clears outputs without waiting for a clock edge.
      check("pre-reset tub lit", tub_h, 4'b1000);
      #2 rst_n = 1'b0;
      #1;
      check("async reset tub", tub_h, 0);
      check("async reset seg", seg_h, 8'h00);
      check("async reset seg dec", seg_d, 8'h00);
      @(negedge clk);
      rst_n    = 1'b1;
      blank_lz = 1'b0;
      blink_en = 4'b0001;
      pulse_load(16'h1234, 4'b0001);

      // Blink: frames 1 lit, 2-3 dark (segments and dp), 4-5 lit; other digits steady.
      for (int f = 1; f <= 5; f++) begin
         wait_frame();
         if (f == 2 || f == 3)
            push_frame({{S1,1'b0},{S2,1'b0},{S3,1'b0},8'h00}, {{S1,1'b0},{S2,1'b0},{S3,1'b0},8'h00});
         else
            push_frame({{S1,1'b0},{S2,1'b0},{S3,1'b0},{S4,1'b1}}, {{S1,1'b0},{S2,1'b0},{S3,1'b0},{S4,1'b1}});
         wait_empty();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
